// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: drives PC advance with credits, issues one RAM
// read per issued PC and buffers returned {pc, instr} pairs for decode.
module instr_fetch_queue #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc_in,
  output logic                     pc_en,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [INSTR_W-1:0]       mem_rdata,
  input  logic                     halt_req,
  input  logic                     flush,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic credit_ok_c;
  logic push_c;
  logic pop_c;

  // Credits: queued entries plus the outstanding read must leave room.
  assign credit_ok_c = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
  assign pc_en       = !reset && !flush && (state_q == ST_RUN) && !halt_req && credit_ok_c;
  assign mem_rd_en   = pc_en;
  assign mem_addr    = pc_in;

  assign push_c      = inflight_q && !flush && !reset;
  assign instr_valid = (count_q != '0);
  assign pop_c       = instr_valid && instr_ready;
  assign instr_data  = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign halted      = (state_q == ST_HALTED);
  assign count       = count_q;

  // Next-state: FSM, pointers, occupancy and in-flight tracking.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = pc_en;

    case (state_q)
      ST_RUN:    if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt_req)        state_d = ST_RUN;
        else if (!inflight_q) state_d = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);

    // Flush empties the queue and forgets the outstanding read; FSM untouched.
    if (flush) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Datapath storage: issued PC and queue entries need no reset.
  always_ff @(posedge clk) begin
    if (pc_en) pc_q <= pc_in;
    if (push_c) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  // The credit scheme must make a push into a full queue impossible.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push_c && (count_q == CNT_W'(DEPTH))));

endmodule
